// File: rtl/buzz_scheduler.sv
// Buzzer arbiter: latches one-cycle alert requests from three sources and plays the
// granted source's beep pattern (tone / on / off / repeat) on a millisecond time base.
module buzz_scheduler #(
    parameter int unsigned CLK_PER_MS = 100_000,
    parameter int unsigned HZ0        = 880,
    parameter int unsigned ON0        = 50,
    parameter int unsigned REP0       = 1,
    parameter int unsigned HZ1        = 440,
    parameter int unsigned ON1        = 400,
    parameter int unsigned REP1       = 1,
    parameter int unsigned HZ2        = 660,
    parameter int unsigned ON2        = 200,
    parameter int unsigned OFF2       = 200,
    parameter int unsigned REP2       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic        cancel,
    output logic [11:0] play_hz,
    output logic        busy,
    output logic [1:0]  act_id,
    output logic        done
);

    localparam int unsigned CW       = $clog2(CLK_PER_MS);
    localparam int unsigned OFF_LOW  = 100;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLK_PER_MS - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t        state;
    logic [2:0]    pend;
    logic [1:0]    cur;
    logic [3:0]    rep;
    logic [CW-1:0] cyc;
    logic [11:0]   ms;

    logic [1:0]    top_k;
    logic          grant_en;
    logic [2:0]    grant_mask;
    logic [11:0]   phase_len;
    logic          phase_end;

    function automatic logic [11:0] hz_of(input logic [1:0] k);
        case (k)
            2'd2:    hz_of = 12'(HZ2);
            2'd1:    hz_of = 12'(HZ1);
            default: hz_of = 12'(HZ0);
        endcase
    endfunction

    function automatic logic [11:0] on_of(input logic [1:0] k);
        case (k)
            2'd2:    on_of = 12'(ON2);
            2'd1:    on_of = 12'(ON1);
            default: on_of = 12'(ON0);
        endcase
    endfunction

    function automatic logic [11:0] off_of(input logic [1:0] k);
        off_of = (k == 2'd2) ? 12'(OFF2) : 12'(OFF_LOW);
    endfunction

    function automatic logic [3:0] rep_of(input logic [1:0] k);
        case (k)
            2'd2:    rep_of = 4'(REP2 - 1);
            2'd1:    rep_of = 4'(REP1 - 1);
            default: rep_of = 4'(REP0 - 1);
        endcase
    endfunction

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        top_k      = 2'd0;
        grant_en   = 1'b0;
        grant_mask = 3'b000;
        if (pend[2])      top_k = 2'd2;
        else if (pend[1]) top_k = 2'd1;

        // While active, only a same-source retrigger or a higher source can take over.
        if (|pend)
            grant_en = (state == IDLE) || (top_k >= cur);
        if (grant_en)
            grant_mask = 3'b001 << top_k;

        phase_len = (state == ON) ? on_of(cur) : off_of(cur);
        phase_end = (ms == phase_len - 12'd1) && (cyc == CYC_LAST);
    end

    // NOTE: all state here uses non-blocking assignments so every register sees
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pend    <= 3'b000;
            cur     <= 2'd0;
            rep     <= 4'd0;
            cyc     <= '0;
            ms      <= 12'd0;
            play_hz <= 12'd0;
            busy    <= 1'b0;
            act_id  <= 2'd0;
            done    <= 1'b0;
        end else if (cancel) begin
            state   <= IDLE;
            pend    <= 3'b000;
            cur     <= 2'd0;
            rep     <= 4'd0;
            cyc     <= '0;
            ms      <= 12'd0;
            play_hz <= 12'd0;
            busy    <= 1'b0;
            act_id  <= 2'd0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            // A request arriving in the grant cycle re-sets the bit just cleared.
            pend <= (pend & ~grant_mask) | req;

            if (grant_en) begin
                state   <= ON;
                cur     <= top_k;
                rep     <= rep_of(top_k);
                cyc     <= '0;
                ms      <= 12'd0;
                play_hz <= hz_of(top_k);
                busy    <= 1'b1;
                act_id  <= top_k;
            end else if (state != IDLE) begin
                if (phase_end) begin
                    cyc <= '0;
                    ms  <= 12'd0;
                    if (state == ON) begin
                        play_hz <= 12'd0;
                        if (rep == 4'd0) begin
                            state  <= IDLE;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            act_id <= 2'd0;
                            cur    <= 2'd0;
                        end else begin
                            state <= OFF;
                        end
                    end else begin
                        state   <= ON;
                        rep     <= rep - 4'd1;
                        play_hz <= hz_of(cur);
                    end
                end else if (cyc == CYC_LAST) begin
                    cyc <= '0;
                    ms  <= ms + 12'd1;
                end else begin
                    cyc <= cyc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_buzz_scheduler.sv
// Directed bench for buzz_scheduler with a short time base (10 clk/ms) and
// hand-computed cycle positions for every tone edge.
module tb_buzz_scheduler;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic        cancel;
    logic [11:0] play_hz;
    logic        busy;
    logic [1:0]  act_id;
    logic        done;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    buzz_scheduler #(
        .CLK_PER_MS(10),
        .HZ0(880), .ON0(3), .REP0(1),
        .HZ1(440), .ON1(5), .REP1(1),
        .HZ2(660), .ON2(2), .OFF2(2), .REP2(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .cancel(cancel),
        .play_hz(play_hz),
        .busy(busy),
        .act_id(act_id),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request pulse; returns in the cycle after the pulse.
    task automatic pulse(input logic [2:0] r);
        req = r;
        tick();
        req = 3'b000;
    endtask

    // Checks n consecutive cycles against a constant output set, then one check call.
    task automatic expect_wave(input string tag, input int n, input logic [11:0] hz,
                               input logic b, input logic [1:0] a);
        int errs = 0;
        for (int i = 0; i < n; i++) begin
            if (play_hz !== hz || busy !== b || act_id !== a || done !== 1'b0) errs++;
            tick();
        end
        check(tag, errs, 0);
    endtask

    task automatic expect_idle_done(input string tag);
        check({tag, "_done"}, done, 1);
        check({tag, "_hz"}, play_hz, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_act"}, act_id, 0);
    endtask

    initial begin
        int d0;
        rst = 1'b1; req = 3'b000; cancel = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_hz", play_hz, 0);
        check("rst_busy", busy, 0);
        check("rst_act", act_id, 0);
        check("rst_done", done, 0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Key-click: tone from t+2, done at t+32.
        pulse(3'b001);
        check("kc_lat_hz", play_hz, 0);
        tick();
        check("kc_act", act_id, 0);
        expect_wave("kc_on", 30, 880, 1, 0);
        expect_idle_done("kc_end");
        tick();
        check("kc_done_once", done, 0);

        // Alarm: 3 beeps of 20 cycles with 20-cycle gaps, busy 100 cycles.
        d0 = done_cnt;
        pulse(3'b100);
        tick();
        expect_wave("al_on1", 20, 660, 1, 2);
        expect_wave("al_off1", 20, 0, 1, 2);
        expect_wave("al_on2", 20, 660, 1, 2);
        expect_wave("al_off2", 20, 0, 1, 2);
        expect_wave("al_on3", 20, 660, 1, 2);
        expect_idle_done("al_end");
        tick();
        check("al_done_cnt", done_cnt - d0, 1);

        // Preemption of countdown by alarm, with key-click queued during the alarm.
        d0 = done_cnt;
        pulse(3'b010);
        tick();
        expect_wave("pre_cd", 13, 440, 1, 1);
        pulse(3'b100);
        check("pre_hold_hz", play_hz, 440);
        check("pre_hold_done", done, 0);
        tick();
        expect_wave("pre_al_a", 5, 660, 1, 2);
        pulse(3'b001);
        expect_wave("pre_al_b", 14, 660, 1, 2);
        expect_wave("pre_off1", 20, 0, 1, 2);
        expect_wave("pre_on2", 20, 660, 1, 2);
        expect_wave("pre_off2", 20, 0, 1, 2);
        expect_wave("pre_on3", 20, 660, 1, 2);
        expect_idle_done("pre_al_end");
        tick();
        expect_wave("q_kc", 30, 880, 1, 0);
        expect_idle_done("q_kc_end");
        tick();
        expect_wave("pre_no_replay", 60, 0, 0, 0);
        check("pre_done_cnt", done_cnt - d0, 2);

        // Retrigger countdown mid-ON: 50 cycles from the retrigger grant.
        pulse(3'b010);
        tick();
        expect_wave("rt_first", 20, 440, 1, 1);
        pulse(3'b010);
        check("rt_hold_hz", play_hz, 440);
        tick();
        expect_wave("rt_restart", 50, 440, 1, 1);
        expect_idle_done("rt_end");
        tick();

        // Simultaneous requests: alarm, countdown, key-click with one silent cycle each.
        pulse(3'b111);
        check("sim_lat_hz", play_hz, 0);
        tick();
        expect_wave("sim_al_on1", 20, 660, 1, 2);
        expect_wave("sim_al_off1", 20, 0, 1, 2);
        expect_wave("sim_al_on2", 20, 660, 1, 2);
        expect_wave("sim_al_off2", 20, 0, 1, 2);
        expect_wave("sim_al_on3", 20, 660, 1, 2);
        expect_idle_done("sim_al_end");
        tick();
        expect_wave("sim_cd", 50, 440, 1, 1);
        expect_idle_done("sim_cd_end");
        tick();
        expect_wave("sim_kc", 30, 880, 1, 0);
        expect_idle_done("sim_kc_end");
        tick();
        check("sim_idle_busy", busy, 0);

        // Cancel mid-alarm with a key-click pending: everything flushed.
        d0 = done_cnt;
        pulse(3'b100);
        tick();
        expect_wave("can_al", 3, 660, 1, 2);
        pulse(3'b001);
        tick(); tick(); tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("can_hz", play_hz, 0);
        check("can_busy", busy, 0);
        check("can_act", act_id, 0);
        check("can_done", done, 0);
        expect_wave("can_quiet", 40, 0, 0, 0);
        check("can_done_cnt", done_cnt - d0, 0);

        // cancel beats a simultaneous request.
        cancel = 1'b1;
        req = 3'b100;
        tick();
        cancel = 1'b0;
        req = 3'b000;
        expect_wave("can_vs_req", 10, 0, 0, 0);

        // Asynchronous reset mid-ON clears outputs before any clock edge.
        pulse(3'b100);
        tick();
        check("ar_pre_hz", play_hz, 660);
        #2 rst = 1'b0;
        #1;
        check("ar_hz", play_hz, 0);
        check("ar_busy", busy, 0);
        check("ar_act", act_id, 0);
        tick();
        rst = 1'b1;
        tick();
        expect_wave("ar_quiet", 20, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
